// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: control-bit positions and the memory-stage state type.
package pipeline_pkg;

    localparam int MEM_READ_BIT   = 0;
    localparam int MEM_WRITE_BIT  = 1;
    localparam int REG_WRITE_BIT  = 0;
    localparam int MEM_TO_REG_BIT = 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register; a bubble loads all-zero fields.
module mem_wb_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        bubble,
    input  logic [31:0] result,
    input  logic [31:0] read_data,
    input  logic [4:0]  reg_dest,
    input  logic [1:0]  wb_ctrl,
    output logic [31:0] wb_result,
    output logic [31:0] wb_read_data,
    output logic [4:0]  wb_reg_dest,
    output logic [1:0]  wb_ctrl_q
);

    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            wb_result    <= '0;
            wb_read_data <= '0;
            wb_reg_dest  <= '0;
            wb_ctrl_q    <= '0;
        end else begin
            wb_result    <= result;
            wb_read_data <= read_data;
            wb_reg_dest  <= reg_dest;
            wb_ctrl_q    <= wb_ctrl;
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: req/ack data-memory port, upstream stall and MEM/WB register.
// state | meaning
// IDLE  | no access outstanding; non-memory instructions pass straight to MEM/WB
// BUSY  | request issued, waiting for mem_ack or the timeout
module mem_stage_ctrl
    import pipeline_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] result,
    input  logic [31:0] write_data,
    input  logic [4:0]  RegDest,
    input  logic [3:0]  control_signals_M,
    input  logic [1:0]  control_signals_WB,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic [31:0] wb_result,
    output logic [31:0] wb_read_data,
    output logic [4:0]  wb_RegDest,
    output logic [1:0]  wb_control_signals,
    output logic        mem_error
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(ACK_TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       lat_dest;
    logic [1:0]       lat_wb;

    logic        mem_read, mem_write, memop, timeout;
    logic        nxt_bubble;
    logic [31:0] nxt_result, nxt_rdata;
    logic [4:0]  nxt_dest;
    logic [1:0]  nxt_wb;
    logic        unused_m;

    assign mem_read  = control_signals_M[MEM_READ_BIT];
    assign mem_write = control_signals_M[MEM_WRITE_BIT];
    assign memop     = mem_read | mem_write;
    assign unused_m  = ^control_signals_M[3:2];

    // An ack on the timeout cycle wins over the timeout.
    assign timeout = (state == BUSY) && !mem_ack && (cnt == CNT_TERM);

    assign stall = !rst && (((state == IDLE) && memop) ||
                            ((state == BUSY) && !mem_ack && !timeout));

    always_comb begin
        nxt_bubble = 1'b1;
        nxt_result = '0;
        nxt_rdata  = '0;
        nxt_dest   = '0;
        nxt_wb     = '0;
        if (state == IDLE && !memop) begin
            nxt_bubble = 1'b0;
            nxt_result = result;
            nxt_dest   = RegDest;
            nxt_wb     = control_signals_WB;
        end else if (state == BUSY && mem_ack) begin
            nxt_bubble = 1'b0;
            nxt_result = mem_addr;
            nxt_rdata  = mem_we ? 32'd0 : mem_rdata;
            nxt_dest   = lat_dest;
            nxt_wb     = lat_wb;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            lat_dest  <= '0;
            lat_wb    <= '0;
            mem_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (memop) begin
                        state     <= BUSY;
                        cnt       <= '0;
                        mem_req   <= 1'b1;
                        mem_we    <= mem_write;
                        mem_addr  <= result;
                        mem_wdata <= write_data;
                        lat_dest  <= RegDest;
                        lat_wb    <= control_signals_WB;
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end else if (timeout) begin
                        mem_req   <= 1'b0;
                        mem_error <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    mem_wb_reg u_mem_wb (
        .clk          (clk),
        .rst          (rst),
        .bubble       (nxt_bubble),
        .result       (nxt_result),
        .read_data    (nxt_rdata),
        .reg_dest     (nxt_dest),
        .wb_ctrl      (nxt_wb),
        .wb_result    (wb_result),
        .wb_read_data (wb_read_data),
        .wb_reg_dest  (wb_RegDest),
        .wb_ctrl_q    (wb_control_signals)
    );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: per-cycle vector table plus timeout and reset-abort sequences.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] result, write_data, mem_rdata;
    logic [4:0]  RegDest;
    logic [3:0]  control_signals_M;
    logic [1:0]  control_signals_WB;
    logic        mem_ack;
    logic        mem_req, mem_we, stall, mem_error;
    logic [31:0] mem_addr, mem_wdata, wb_result, wb_read_data;
    logic [4:0]  wb_RegDest;
    logic [1:0]  wb_control_signals;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_stage_ctrl #(.ACK_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .result(result), .write_data(write_data),
        .RegDest(RegDest), .control_signals_M(control_signals_M),
        .control_signals_WB(control_signals_WB), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .stall(stall), .wb_result(wb_result),
        .wb_read_data(wb_read_data), .wb_RegDest(wb_RegDest),
        .wb_control_signals(wb_control_signals), .mem_error(mem_error)
    );

    typedef struct {
        logic [31:0] res, wd;
        logic [4:0]  rd;
        logic [3:0]  m;
        logic [1:0]  wb;
        logic        ack;
        logic [31:0] rdata;
        logic        e_stall, e_req, e_we;
        logic [31:0] e_addr, e_wdata, e_wbres, e_wbrd;
        logic [4:0]  e_wbdest;
        logic [1:0]  e_wbctl;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] res, wd, input logic [4:0] rd,
                                input logic [3:0] m, input logic [1:0] wb, input logic ack,
                                input logic [31:0] rdata, input logic e_stall, e_req, e_we,
                                input logic [31:0] e_addr, e_wdata, e_wbres, e_wbrd,
                                input logic [4:0] e_wbdest, input logic [1:0] e_wbctl);
        vec_t v;
        v.res = res; v.wd = wd; v.rd = rd; v.m = m; v.wb = wb; v.ack = ack; v.rdata = rdata;
        v.e_stall = e_stall; v.e_req = e_req; v.e_we = e_we; v.e_addr = e_addr;
        v.e_wdata = e_wdata; v.e_wbres = e_wbres; v.e_wbrd = e_wbrd;
        v.e_wbdest = e_wbdest; v.e_wbctl = e_wbctl;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] res, wd, input logic [4:0] rd,
                         input logic [3:0] m, input logic [1:0] wb, input logic ack,
                         input logic [31:0] rdata);
        result = res; write_data = wd; RegDest = rd; control_signals_M = m;
        control_signals_WB = wb; mem_ack = ack; mem_rdata = rdata;
    endtask

    task automatic chk_wb(input string tag, input logic [31:0] r, rd, input logic [4:0] d,
                          input logic [1:0] c);
        chk({tag, ".wb_result"}, wb_result, r);
        chk({tag, ".wb_read_data"}, wb_read_data, rd);
        chk({tag, ".wb_RegDest"}, {27'd0, wb_RegDest}, {27'd0, d});
        chk({tag, ".wb_ctrl"}, {30'd0, wb_control_signals}, {30'd0, c});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[14];
    int   n_busy;

    initial begin
        vecs[0]  = mk(32'h1234, 0, 5, 4'b0000, 2'b01, 0, 0,            0, 0, 0, 0, 0, 32'h1234, 0, 5, 2'b01);
        vecs[1]  = mk(32'h40, 0, 7, 4'b0001, 2'b11, 0, 0,              1, 1, 0, 32'h40, 0, 0, 0, 0, 0);
        vecs[2]  = mk(32'h40, 0, 7, 4'b0001, 2'b11, 0, 0,              1, 1, 0, 32'h40, 0, 0, 0, 0, 0);
        vecs[3]  = mk(32'h40, 0, 7, 4'b0001, 2'b11, 0, 0,              1, 1, 0, 32'h40, 0, 0, 0, 0, 0);
        vecs[4]  = mk(32'h40, 0, 7, 4'b0001, 2'b11, 0, 0,              1, 1, 0, 32'h40, 0, 0, 0, 0, 0);
        vecs[5]  = mk(32'h40, 0, 7, 4'b0001, 2'b11, 1, 32'hDEADBEEF,   0, 0, 0, 0, 0, 32'h40, 32'hDEADBEEF, 7, 2'b11);
        vecs[6]  = mk(32'h80, 32'hCAFE, 3, 4'b0010, 2'b00, 0, 0,       1, 1, 1, 32'h80, 32'hCAFE, 0, 0, 0, 0);
        vecs[7]  = mk(32'h80, 32'hCAFE, 3, 4'b0010, 2'b00, 1, 32'h5555, 0, 0, 0, 0, 0, 32'h80, 0, 3, 2'b00);
        vecs[8]  = mk(32'h99, 0, 9, 4'b0000, 2'b01, 1, 32'h77,         0, 0, 0, 0, 0, 32'h99, 0, 9, 2'b01);
        vecs[9]  = mk(32'h100, 0, 4, 4'b0001, 2'b11, 0, 0,             1, 1, 0, 32'h100, 0, 0, 0, 0, 0);
        vecs[10] = mk(32'h100, 0, 4, 4'b0001, 2'b11, 1, 32'h1111,      0, 0, 0, 0, 0, 32'h100, 32'h1111, 4, 2'b11);
        vecs[11] = mk(32'h104, 32'h2222, 6, 4'b0011, 2'b00, 0, 0,      1, 1, 1, 32'h104, 32'h2222, 0, 0, 0, 0);
        vecs[12] = mk(32'h104, 32'h2222, 6, 4'b0011, 2'b00, 1, 32'h3333, 0, 0, 0, 0, 0, 32'h104, 0, 6, 2'b00);
        vecs[13] = mk(32'h5, 0, 1, 4'b1100, 2'b01, 0, 0,               0, 0, 0, 0, 0, 32'h5, 0, 1, 2'b01);

        // Reset with a load presented: stall must stay low.
        rst = 1'b1;
        drive(32'h40, 0, 7, 4'b0001, 2'b11, 0, 0);
        step();
        step();
        chk("rst.stall", {31'd0, stall}, 0);
        chk("rst.mem_req", {31'd0, mem_req}, 0);
        chk("rst.mem_error", {31'd0, mem_error}, 0);
        chk_wb("rst", 0, 0, 0, 0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].res, vecs[i].wd, vecs[i].rd, vecs[i].m, vecs[i].wb,
                  vecs[i].ack, vecs[i].rdata);
            #1;
            chk($sformatf("v%0d.stall", i), {31'd0, stall}, {31'd0, vecs[i].e_stall});
            step();
            chk($sformatf("v%0d.mem_req", i), {31'd0, mem_req}, {31'd0, vecs[i].e_req});
            if (vecs[i].e_req) begin
                chk($sformatf("v%0d.mem_we", i), {31'd0, mem_we}, {31'd0, vecs[i].e_we});
                chk($sformatf("v%0d.mem_addr", i), mem_addr, vecs[i].e_addr);
                chk($sformatf("v%0d.mem_wdata", i), mem_wdata, vecs[i].e_wdata);
            end
            chk_wb($sformatf("v%0d", i), vecs[i].e_wbres, vecs[i].e_wbrd,
                   vecs[i].e_wbdest, vecs[i].e_wbctl);
            chk($sformatf("v%0d.mem_error", i), {31'd0, mem_error}, 0);
        end

        // Load never acknowledged: 16 BUSY cycles, stall drops on the last one.
        drive(32'h200, 0, 2, 4'b0001, 2'b11, 0, 0);
        #1;
        chk("to.stall_idle", {31'd0, stall}, 1);
        step();
        n_busy = 0;
        while (mem_req === 1'b1 && n_busy < 40) begin
            n_busy++;
            chk($sformatf("to.stall_c%0d", n_busy), {31'd0, stall}, (n_busy < 16) ? 32'd1 : 32'd0);
            step();
            chk($sformatf("to.bubble_c%0d", n_busy), {30'd0, wb_control_signals}, 0);
        end
        chk("to.busy_cycles", n_busy, 16);
        chk("to.mem_error", {31'd0, mem_error}, 1);
        chk_wb("to", 0, 0, 0, 0);
        drive(32'h33, 0, 8, 4'b0000, 2'b01, 0, 0);
        step();
        step();
        chk("to.error_sticky", {31'd0, mem_error}, 1);
        chk_wb("to_alu", 32'h33, 0, 8, 2'b01);

        // Reset two cycles into BUSY; a late ack must be ignored.
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("ra.error_clr", {31'd0, mem_error}, 0);
        drive(32'h300, 0, 3, 4'b0001, 2'b11, 0, 0);
        step();
        chk("ra.req_up", {31'd0, mem_req}, 1);
        step();
        rst = 1'b1;
        #1;
        chk("ra.stall_in_rst", {31'd0, stall}, 0);
        step();
        chk("ra.mem_req", {31'd0, mem_req}, 0);
        chk("ra.mem_addr", mem_addr, 0);
        chk("ra.mem_we", {31'd0, mem_we}, 0);
        chk_wb("ra", 0, 0, 0, 0);
        rst = 1'b0;
        drive(0, 0, 0, 4'b0000, 2'b00, 1, 32'hABCD);
        #1;
        chk("ra.stall_ack", {31'd0, stall}, 0);
        step();
        mem_ack = 1'b0;
        chk("ra.req_after", {31'd0, mem_req}, 0);
        chk("ra.err_after", {31'd0, mem_error}, 0);
        chk_wb("ra_after", 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
